// File: rtl/config_loader.sv
// config_loader: host-word to serial configuration chain sequencer.
// Words arrive on a valid/ready stream and are shifted LSB-first into the
// tile chain. After loading, the chain is recirculated once so its ones
// count can be compared against the count seen while loading. The
// recirculation leaves the loaded contents unchanged.
module config_loader #(
    parameter int CHAIN_LENGTH = 512,
    parameter int WORD_WIDTH   = 8,
    parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                  clock,
    input  logic                  config_nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_in,
    input  logic                  chain_out,
    output logic                  chain_enable,
    output logic                  chain_nreset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Holds 0..WORD_WIDTH, so a one-bit word still fits.
    localparam int WB_WIDTH = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [WB_WIDTH-1:0]  WB_LAST  = WB_WIDTH'(WORD_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_SHIFT,
        S_VERIFY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WB_WIDTH-1:0]   wbit_q, wbit_d;
    // bit_cnt counts up while loading and reaches CHAIN_LENGTH on entry to
    // VERIFY. It then counts back down so it also times the recirculation.
    logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_WIDTH-1:0]  ones_q, ones_d;
    logic [CNT_WIDTH-1:0]  vfy_q, vfy_d;

    // Next-state, datapath and output decode for the load/verify sequencer.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        wbit_d       = wbit_q;
        bit_cnt_d    = bit_cnt_q;
        ones_d       = ones_q;
        vfy_d        = vfy_q;
        word_ready   = 1'b0;
        chain_in     = 1'b0;
        chain_enable = 1'b0;
        chain_nreset = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                done  = (state_q == S_DONE);
                error = (state_q == S_ERROR);
                if (start) begin
                    state_d   = S_CLEAR;
                    bit_cnt_d = '0;
                    ones_d    = '0;
                    vfy_d     = '0;
                    wbit_d    = '0;
                end
            end
            S_CLEAR: begin
                busy         = 1'b1;
                chain_nreset = 1'b0;
                state_d      = S_LOAD;
            end
            S_LOAD: begin
                busy       = 1'b1;
                word_ready = 1'b1;
                if (word_valid) begin
                    shift_d = word_data;
                    wbit_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy         = 1'b1;
                chain_enable = 1'b1;
                chain_in     = shift_q[0];
                shift_d      = shift_q >> 1;
                bit_cnt_d    = bit_cnt_q + CNT_ONE;
                wbit_d       = wbit_q + WB_WIDTH'(1);
                ones_d       = ones_q + CNT_WIDTH'(shift_q[0]);
                // A full chain wins over a partial word: leftover bits are dropped.
                if (bit_cnt_d == CNT_LAST) begin
                    state_d = S_VERIFY;
                end else if (wbit_d == WB_LAST) begin
                    state_d = S_LOAD;
                end
            end
            S_VERIFY: begin
                busy         = 1'b1;
                chain_enable = 1'b1;
                chain_in     = chain_out;
                vfy_d        = vfy_q + CNT_WIDTH'(chain_out);
                bit_cnt_d    = bit_cnt_q - CNT_ONE;
                if (bit_cnt_q == CNT_ONE) begin
                    state_d = (vfy_d == ones_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!config_nreset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            wbit_q    <= '0;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            vfy_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            wbit_q    <= wbit_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            vfy_q     <= vfy_d;
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Testbench for config_loader. It builds a 16-bit chain and a 12-bit chain,
// and models the tile chain as a shift register. Results are compared
// against expectations that are worked out from word values and chain
// length.
module tb_config_loader;

    typedef struct {
        int          edges;
        int          enables;
        int          readies;
        int          clears;
        int          viol;
        bit          timeout;
        logic        done;
        logic        err;
        logic        busy;
        logic [15:0] chain;
    } run_t;

    logic        clock = 1'b0;
    logic        config_nreset;
    logic        start;
    logic        word_valid;
    logic [7:0]  word_data;
    logic        sel;          // 0: 16-bit chain build, 1: 12-bit chain build
    logic [15:0] flip_mask;
    logic [7:0]  words [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    logic rdy_a, cin_a, en_a, nrst_a, busy_a, done_a, err_a;
    logic rdy_b, cin_b, en_b, nrst_b, busy_b, done_b, err_b;
    logic [15:0] chain_a = '0;
    logic [11:0] chain_b = '0;
    logic [15:0] chain_a_f;
    logic        start_a, start_b;

    assign chain_a_f = chain_a ^ flip_mask;
    assign start_a   = start & ~sel;
    assign start_b   = start & sel;

    config_loader #(.CHAIN_LENGTH(16), .WORD_WIDTH(8)) dut_a (
        .clock(clock), .config_nreset(config_nreset), .start(start_a),
        .word_data(word_data), .word_valid(word_valid), .word_ready(rdy_a),
        .chain_in(cin_a), .chain_out(chain_a_f[0]), .chain_enable(en_a),
        .chain_nreset(nrst_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    config_loader #(.CHAIN_LENGTH(12), .WORD_WIDTH(8)) dut_b (
        .clock(clock), .config_nreset(config_nreset), .start(start_b),
        .word_data(word_data), .word_valid(word_valid), .word_ready(rdy_b),
        .chain_in(cin_b), .chain_out(chain_b[0]), .chain_enable(en_b),
        .chain_nreset(nrst_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    // Tile chain models: config_in enters at the top, config_out is bit 0.
    always @(posedge clock) begin
        if (!nrst_a) chain_a <= '0;
        else if (en_a) chain_a <= {cin_a, chain_a_f[15:1]};
        if (!nrst_b) chain_b <= '0;
        else if (en_b) chain_b <= {cin_b, chain_b[11:1]};
    end

    wire        rdy   = sel ? rdy_b  : rdy_a;
    wire        cin   = sel ? cin_b  : cin_a;
    wire        en    = sel ? en_b   : en_a;
    wire        nrst  = sel ? nrst_b : nrst_a;
    wire        busy  = sel ? busy_b : busy_a;
    wire        done  = sel ? done_b : done_a;
    wire        err   = sel ? err_b  : err_a;
    wire [15:0] chain_sel = sel ? {4'h0, chain_b} : chain_a;

    // Expected outcome of one load from chain length, valid gap and word values.
    function automatic run_t expect_run(input int len, input int gap, input bit flip);
        run_t r;
        int rem, take, used;
        logic [31:0] packed_words;
        rem = len; used = 0;
        r.edges = 1 + len;                     // CLEAR cycle + verify pass
        while (rem > 0) begin
            take = (rem < 8) ? rem : 8;
            r.edges += 1 + take;               // one LOAD plus the bits shifted
            rem -= take;
            used++;
        end
        r.edges   += gap * (used - 1);
        r.readies  = used + gap * (used - 1);
        r.enables  = 2 * len;
        r.clears   = 1;
        r.viol     = 0;
        r.timeout  = 1'b0;
        r.done     = !flip;
        r.err      = flip;
        r.busy     = 1'b0;
        packed_words = {16'h0, words[1], words[0]};
        packed_words = packed_words & ((32'd1 << len) - 32'd1);
        r.chain    = packed_words[15:0] ^ (flip ? 16'h0020 : 16'h0000);
        return r;
    endfunction

    // Drives one complete load from start until done/error and records what happened.
    task automatic run_load(input int gap, input bit flip, input bit noise, input int len, output run_t r);
        int idx, hold;
        idx = 0; hold = 0;
        r.edges = 0; r.enables = 0; r.readies = 0; r.clears = 0; r.viol = 0; r.timeout = 1'b0;
        @(negedge clock);
        start = 1'b1; word_valid = 1'b0;
        @(negedge clock);
        start = 1'b0;
        while (!(done || err)) begin
            if (r.edges >= 300) begin
                r.timeout = 1'b1;
                break;
            end
            if (en)  r.enables++;
            if (rdy) r.readies++;
            if (!nrst) r.clears++;
            if (en && !busy) r.viol++;
            if (!busy && cin) r.viol++;
            if (rdy && en) r.viol++;
            word_valid = (idx < 2) && (hold == 0);
            word_data  = (idx < 2) ? words[idx] : 8'h00;
            if (rdy && word_valid) begin
                idx++;
                hold = gap;
            end else if (rdy && hold > 0) begin
                hold--;
            end
            start = noise && (r.edges == 1 || r.edges == 5 || r.edges == 25);
            flip_mask = (flip && en && r.enables == len + 1) ? 16'h0020 : 16'h0000;
            @(negedge clock);
            r.edges++;
        end
        start = 1'b0; word_valid = 1'b0; flip_mask = '0;
        r.done = done; r.err = err; r.busy = busy; r.chain = chain_sel;
    endtask

    task automatic test_reset();
        config_nreset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({rdy_a, cin_a, en_a, nrst_a, busy_a, done_a, err_a} !== 7'b0001000) begin
            errors++;
            $display("FAIL reset_a outputs got %b expected 0001000", {rdy_a, cin_a, en_a, nrst_a, busy_a, done_a, err_a});
        end
        checks++;
        if ({rdy_b, cin_b, en_b, nrst_b, busy_b, done_b, err_b} !== 7'b0001000) begin
            errors++;
            $display("FAIL reset_b outputs got %b expected 0001000", {rdy_b, cin_b, en_b, nrst_b, busy_b, done_b, err_b});
        end
        config_nreset = 1'b1;
        @(negedge clock);
        $display("test_reset done");
    endtask

    // Fixed words 0xA5, 0x3C (or given), valid held or gapped, optional start noise / bit flip.
    task automatic test_load(input string name, input int len, input int gap, input bit flip, input bit noise);
        run_t got, exp;
        exp = expect_run(len, gap, flip);
        run_load(gap, flip, noise, len, got);
        checks++; if (got.timeout !== exp.timeout) begin errors++; $display("FAIL %s timeout got %0d expected %0d", name, got.timeout, exp.timeout); end
        checks++; if (got.edges   !== exp.edges)   begin errors++; $display("FAIL %s cycles got %0d expected %0d", name, got.edges, exp.edges); end
        checks++; if (got.enables !== exp.enables) begin errors++; $display("FAIL %s enables got %0d expected %0d", name, got.enables, exp.enables); end
        checks++; if (got.readies !== exp.readies) begin errors++; $display("FAIL %s ready_cycles got %0d expected %0d", name, got.readies, exp.readies); end
        checks++; if (got.clears  !== exp.clears)  begin errors++; $display("FAIL %s clear_cycles got %0d expected %0d", name, got.clears, exp.clears); end
        checks++; if (got.viol    !== exp.viol)    begin errors++; $display("FAIL %s illegal_outputs got %0d expected %0d", name, got.viol, exp.viol); end
        checks++; if ({got.done, got.err, got.busy} !== {exp.done, exp.err, exp.busy}) begin
            errors++; $display("FAIL %s done_err_busy got %b expected %b", name, {got.done, got.err, got.busy}, {exp.done, exp.err, exp.busy});
        end
        checks++; if (got.chain !== exp.chain) begin errors++; $display("FAIL %s chain got %h expected %h", name, got.chain, exp.chain); end
        $display("%s words=%h,%h len=%0d gap=%0d cycles=%0d done=%b error=%b chain=%h",
                 name, words[1], words[0], len, gap, got.edges, got.done, got.err, got.chain);
    endtask

    task automatic test_random_loads();
        for (int i = 0; i < 4; i++) begin
            words[0] = 8'($urandom);
            words[1] = 8'($urandom);
            test_load("random", 16, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
    endtask

    // Reset asserted while bits are being shifted, then a clean reload.
    task automatic test_reset_mid_shift();
        int waited;
        sel = 1'b0;
        words[0] = 8'($urandom);
        words[1] = 8'($urandom);
        @(negedge clock);
        start = 1'b1; word_valid = 1'b1; word_data = words[0];
        @(negedge clock);
        start = 1'b0;
        waited = 0;
        while (!en && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL mid_shift_reach enable got %b expected 1", en); end
        repeat (3) @(negedge clock);
        config_nreset = 1'b0;
        @(negedge clock);
        config_nreset = 1'b1; word_valid = 1'b0;
        checks++;
        if ({rdy, cin, en, nrst, busy, done, err} !== 7'b0001000) begin
            errors++; $display("FAIL mid_shift_reset outputs got %b expected 0001000", {rdy, cin, en, nrst, busy, done, err});
        end
        repeat (2) @(negedge clock);
        checks++; if ({busy, en, rdy} !== 3'b000) begin errors++; $display("FAIL mid_shift_idle busy_en_rdy got %b expected 000", {busy, en, rdy}); end
        $display("test_reset_mid_shift reset applied after %0d cycles", waited + 3);
        test_load("reload", 16, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b0; word_valid = 1'b0; word_data = '0; sel = 1'b0; flip_mask = '0;
        test_reset();
        words[0] = 8'hA5; words[1] = 8'h3C;
        test_load("basic", 16, 0, 1'b0, 1'b0);
        test_load("valid_gap", 16, 5, 1'b0, 1'b0);
        test_load("verify_flip", 16, 0, 1'b1, 1'b0);
        test_load("start_noise", 16, 0, 1'b0, 1'b1);
        test_random_loads();
        sel = 1'b1;
        words[0] = 8'hFF; words[1] = 8'hFF;
        test_load("short_chain", 12, 0, 1'b0, 1'b0);
        sel = 1'b0;
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
